// File: rtl/reorder_buffer_if.sv
// Dispatch/completion/retire bundle for the reorder buffer.
// slave = the ROB itself; master = the core side driving dispatch and ALU results.
interface reorder_buffer_if #(
    parameter int DEPTH        = 16,
    parameter int IDX_W        = 4,
    parameter int PREG_WIDTH   = 6,
    parameter int AREG_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CMPL     = 2,
    parameter int RETIRE_WIDTH = 2
) ();
    logic                               flush;

    logic                               alloc_valid;
    logic                               alloc_ready;
    logic                               alloc_reg_write;
    logic [AREG_WIDTH-1:0]              alloc_rd;
    logic [PREG_WIDTH-1:0]              alloc_prd;
    logic [PREG_WIDTH-1:0]              alloc_old_prd;
    logic [11:0]                        alloc_pc;
    logic [IDX_W-1:0]                   alloc_idx;

    logic [NUM_CMPL-1:0]                cmpl_valid;
    logic [NUM_CMPL*IDX_W-1:0]          cmpl_idx;
    logic [NUM_CMPL*DATA_WIDTH-1:0]     cmpl_data;

    logic [RETIRE_WIDTH-1:0]            ret_valid;
    logic [RETIRE_WIDTH-1:0]            ret_reg_write;
    logic [RETIRE_WIDTH*AREG_WIDTH-1:0] ret_rd;
    logic [RETIRE_WIDTH*PREG_WIDTH-1:0] ret_prd;
    logic [RETIRE_WIDTH*DATA_WIDTH-1:0] ret_data;
    logic [RETIRE_WIDTH*12-1:0]         ret_pc;
    logic [RETIRE_WIDTH-1:0]            free_push;
    logic [RETIRE_WIDTH*PREG_WIDTH-1:0] free_preg;
    logic [IDX_W:0]                     count;
    logic                               empty;

    modport slave (
        input  flush, alloc_valid, alloc_reg_write, alloc_rd, alloc_prd, alloc_old_prd, alloc_pc,
        input  cmpl_valid, cmpl_idx, cmpl_data,
        output alloc_ready, alloc_idx, ret_valid, ret_reg_write, ret_rd, ret_prd, ret_data, ret_pc,
        output free_push, free_preg, count, empty
    );

    modport master (
        output flush, alloc_valid, alloc_reg_write, alloc_rd, alloc_prd, alloc_old_prd, alloc_pc,
        output cmpl_valid, cmpl_idx, cmpl_data,
        input  alloc_ready, alloc_idx, ret_valid, ret_reg_write, ret_rd, ret_prd, ret_data, ret_pc,
        input  free_push, free_preg, count, empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order commit queue: one entry per dispatch, results captured from NUM_CMPL ports, up to RETIRE_WIDTH in-order retires/cycle.
// Completion -> retire is at least one cycle; alloc_ready drops when full or flushing, dropped allocs leave no state.
module reorder_buffer #(
    parameter int DEPTH        = 16,
    parameter int IDX_W        = 4,
    parameter int PREG_WIDTH   = 6,
    parameter int AREG_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CMPL     = 2,
    parameter int RETIRE_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  rob
);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      done_q, done_d;

    logic [DEPTH-1:0]      reg_write_q, reg_write_d;
    logic [AREG_WIDTH-1:0] rd_q      [DEPTH];
    logic [AREG_WIDTH-1:0] rd_d      [DEPTH];
    logic [PREG_WIDTH-1:0] prd_q     [DEPTH];
    logic [PREG_WIDTH-1:0] prd_d     [DEPTH];
    logic [PREG_WIDTH-1:0] old_prd_q [DEPTH];
    logic [PREG_WIDTH-1:0] old_prd_d [DEPTH];
    logic [11:0]           pc_q      [DEPTH];
    logic [11:0]           pc_d      [DEPTH];
    logic [DATA_WIDTH-1:0] data_q    [DEPTH];
    logic [DATA_WIDTH-1:0] data_d    [DEPTH];

    logic                  full;
    logic                  alloc_fire;
    logic [IDX_W-1:0]      tail_idx;
    logic [IDX_W-1:0]      ridx [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0] ret_vld;
    logic [PTR_W-1:0]      ret_cnt;
    logic                  chain;
    logic [IDX_W-1:0]      cidx;

    // Pointers carry a wrap bit so full and empty are distinguishable at equal indices.
    always_comb begin
        tail_idx   = tail_q[IDX_W-1:0];
        full       = (tail_idx == head_q[IDX_W-1:0]) && (tail_q[IDX_W] != head_q[IDX_W]);
        alloc_fire = rob.alloc_valid && !full && !rob.flush;
    end

    assign rob.alloc_ready = !full && !rob.flush;
    assign rob.alloc_idx   = tail_idx;
    assign rob.count       = tail_q - head_q;
    assign rob.empty       = (tail_q == head_q);

    // Retire lanes form a thermometer: each lane needs every older lane to retire too.
    always_comb begin
        ret_vld = '0;
        ret_cnt = '0;
        chain   = !rob.flush;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            ridx[i]    = head_q[IDX_W-1:0] + IDX_W'(i);
            chain      = chain && valid_q[ridx[i]] && done_q[ridx[i]];
            ret_vld[i] = chain;
            if (chain) begin
                ret_cnt = ret_cnt + PTR_W'(1);
            end
        end
    end

    always_comb begin
        rob.ret_valid     = ret_vld;
        rob.ret_reg_write = '0;
        rob.ret_rd        = '0;
        rob.ret_prd       = '0;
        rob.ret_data      = '0;
        rob.ret_pc        = '0;
        rob.free_push     = '0;
        rob.free_preg     = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            rob.ret_reg_write[i]                        = reg_write_q[ridx[i]];
            rob.ret_rd[i*AREG_WIDTH +: AREG_WIDTH]      = rd_q[ridx[i]];
            rob.ret_prd[i*PREG_WIDTH +: PREG_WIDTH]     = prd_q[ridx[i]];
            rob.ret_data[i*DATA_WIDTH +: DATA_WIDTH]    = data_q[ridx[i]];
            rob.ret_pc[i*12 +: 12]                      = pc_q[ridx[i]];
            rob.free_push[i]                            = ret_vld[i] && reg_write_q[ridx[i]];
            rob.free_preg[i*PREG_WIDTH +: PREG_WIDTH]   = old_prd_q[ridx[i]];
        end
    end

    // Order inside the non-flush branch: completions, then retire clears, then the new allocation.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        valid_d     = valid_q;
        done_d      = done_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        prd_d       = prd_q;
        old_prd_d   = old_prd_q;
        pc_d        = pc_q;
        data_d      = data_q;
        cidx        = '0;

        if (rob.flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            // Walk ports high to low so the lowest port's write lands last and wins.
            for (int k = NUM_CMPL - 1; k >= 0; k--) begin
                cidx = rob.cmpl_idx[k*IDX_W +: IDX_W];
                if (rob.cmpl_valid[k] && valid_q[cidx]) begin
                    done_d[cidx] = 1'b1;
                    data_d[cidx] = rob.cmpl_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                if (ret_vld[i]) begin
                    valid_d[ridx[i]] = 1'b0;
                    done_d[ridx[i]]  = 1'b0;
                end
            end
            head_d = head_q + ret_cnt;

            if (alloc_fire) begin
                valid_d[tail_idx]     = 1'b1;
                done_d[tail_idx]      = 1'b0;
                reg_write_d[tail_idx] = rob.alloc_reg_write;
                rd_d[tail_idx]        = rob.alloc_rd;
                prd_d[tail_idx]       = rob.alloc_prd;
                old_prd_d[tail_idx]   = rob.alloc_old_prd;
                pc_d[tail_idx]        = rob.alloc_pc;
                tail_d                = tail_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload is qualified by valid/done, so it needs no reset.
    always_ff @(posedge clk) begin
        reg_write_q <= reg_write_d;
        rd_q        <= rd_d;
        prd_q       <= prd_d;
        old_prd_q   <= old_prd_d;
        pc_q        <= pc_d;
        data_q      <= data_d;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based program-order model.
module tb_reorder_buffer;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    typedef struct {
        int          tag;
        bit          rw;
        logic [4:0]  rd;
        logic [5:0]  prd;
        logic [5:0]  old_prd;
        logic [11:0] pc;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   next_tag;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .rob (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle against the model, then advance the model across the edge.
    task automatic step();
        int         nret;
        bit         acc;
        bit         seen [16];
        logic [1:0] exp_fp;
        int         t;
        #4;
        if (rst) begin
            q.delete();
            next_tag = 0;
        end
        nret = 0;
        if (!rst && !bus.flush)
            while (nret < 2 && nret < q.size() && q[nret].done) nret++;
        exp_fp = '0;
        for (int i = 0; i < nret; i++) exp_fp[i] = q[i].rw;

        chk("count", 64'(bus.count), 64'(q.size()));
        chk("empty", 64'(bus.empty), 64'(q.size() == 0));
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(q.size() < 16 && !bus.flush));
        chk("alloc_idx", 64'(bus.alloc_idx), 64'(next_tag));
        chk("ret_valid", 64'(bus.ret_valid), 64'((1 << nret) - 1));
        chk("free_push", 64'(bus.free_push), 64'(exp_fp));
        for (int i = 0; i < nret; i++) begin
            chk("ret_reg_write", 64'(bus.ret_reg_write[i]), 64'(q[i].rw));
            chk("ret_rd", 64'(bus.ret_rd[i*5 +: 5]), 64'(q[i].rd));
            chk("ret_prd", 64'(bus.ret_prd[i*6 +: 6]), 64'(q[i].prd));
            chk("ret_pc", 64'(bus.ret_pc[i*12 +: 12]), 64'(q[i].pc));
            chk("ret_data", 64'(bus.ret_data[i*32 +: 32]), 64'(q[i].data));
            if (q[i].rw) chk("free_preg", 64'(bus.free_preg[i*6 +: 6]), 64'(q[i].old_prd));
        end

        if (!rst) begin
            if (bus.flush) begin
                q.delete();
                next_tag = 0;
            end else begin
                acc = bus.alloc_valid && (q.size() < 16);
                for (int k = 0; k < 16; k++) seen[k] = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    if (bus.cmpl_valid[k]) begin
                        t = int'(bus.cmpl_idx[k*4 +: 4]);
                        if (!seen[t]) begin
                            seen[t] = 1'b1;
                            foreach (q[j]) if (q[j].tag == t) begin
                                q[j].done = 1'b1;
                                q[j].data = bus.cmpl_data[k*32 +: 32];
                            end
                        end
                    end
                end
                repeat (nret) void'(q.pop_front());
                if (acc) begin
                    q.push_back('{tag: next_tag, rw: bus.alloc_reg_write, rd: bus.alloc_rd,
                                  prd: bus.alloc_prd, old_prd: bus.alloc_old_prd, pc: bus.alloc_pc,
                                  done: 1'b0, data: 32'h0});
                    next_tag = (next_tag + 1) % 16;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input bit rw, input int oldp, input bit [1:0] cv,
                         input int t0, input int t1, input int d0, input int d1, input bit fl);
        bus.flush           = fl;
        bus.alloc_valid     = av;
        bus.alloc_reg_write = rw;
        bus.alloc_rd        = 5'($urandom);
        bus.alloc_prd       = 6'($urandom);
        bus.alloc_old_prd   = 6'(oldp);
        bus.alloc_pc        = 12'($urandom);
        bus.cmpl_valid      = cv;
        bus.cmpl_idx        = {4'(t1), 4'(t0)};
        bus.cmpl_data       = {32'(d1), 32'(d0)};
        step();
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 64'(bus.count), 64'd0);
        chk({tag, "_empty"}, 64'(bus.empty), 64'd1);
        chk({tag, "_ready"}, 64'(bus.alloc_ready), 64'd1);
        chk({tag, "_ret_valid"}, 64'(bus.ret_valid), 64'd0);
    endtask

    initial begin
        int nd [$];
        bit [1:0] cv;
        int t0, t1;
        vectors     = 0;
        miscompares = 0;
        next_tag    = 0;
        rst         = 1'b1;
        bus.flush = 0; bus.alloc_valid = 0; bus.alloc_reg_write = 0; bus.alloc_rd = 0;
        bus.alloc_prd = 0; bus.alloc_old_prd = 0; bus.alloc_pc = 0;
        bus.cmpl_valid = 0; bus.cmpl_idx = 0; bus.cmpl_data = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_state("por");
        chk("por_alloc_idx", 64'(bus.alloc_idx), 64'd0);
        chk("por_free_push", 64'(bus.free_push), 64'd0);
        rst = 1'b0;

        // In-order retire around an out-of-order completion.
        drive(1, 1, 10, 2'b00, 0, 0, 0, 0, 0);
        drive(1, 1, 11, 2'b00, 0, 0, 0, 0, 0);
        drive(1, 1, 12, 2'b00, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 2'b01, 2, 0, 32'h22, 0, 0);
        chk("s2_wait_head", 64'(bus.ret_valid), 64'd0);
        drive(0, 0, 0, 2'b01, 0, 0, 32'h20, 0, 0);
        chk("s2_ret_a", 64'(bus.ret_valid), 64'b01);
        chk("s2_free_a", 64'(bus.free_preg[5:0]), 64'd10);
        drive(0, 0, 0, 2'b01, 1, 0, 32'h21, 0, 0);
        chk("s2_ret_bc", 64'(bus.ret_valid), 64'b11);
        chk("s2_free_bc", 64'(bus.free_preg), 64'({6'd12, 6'd11}));
        idle();
        chk("s2_empty", 64'(bus.empty), 64'd1);

        // Fill to capacity, try one more, then drain two per cycle.
        for (int i = 0; i < 16; i++) drive(1, 1, i, 2'b00, 0, 0, 0, 0, 0);
        chk("s3_full_count", 64'(bus.count), 64'd16);
        chk("s3_full_ready", 64'(bus.alloc_ready), 64'd0);
        drive(1, 1, 63, 2'b00, 0, 0, 0, 0, 0);
        chk("s3_tail_hold", 64'(bus.alloc_idx), 64'd3);
        for (int i = 0; i < 8; i++)
            drive(0, 0, 0, 2'b11, (3 + 2*i) % 16, (4 + 2*i) % 16, int'($urandom), int'($urandom), 0);
        idle();
        chk("s3_drained", 64'(bus.empty), 64'd1);

        // Flush with live entries and simultaneous completions.
        for (int i = 0; i < 5; i++) drive(1, 1, 40 + i, 2'b00, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 2'b11, 3, 4, 32'h33, 32'h44, 0);
        drive(0, 0, 0, 2'b11, 5, 6, 32'h55, 32'h66, 1);
        chk("s5_count", 64'(bus.count), 64'd0);
        chk("s5_alloc_idx", 64'(bus.alloc_idx), 64'd0);
        drive(0, 0, 0, 2'b01, 3, 0, 32'h77, 0, 0);
        chk("s5_stale_count", 64'(bus.count), 64'd0);
        chk("s5_stale_ret", 64'(bus.ret_valid), 64'd0);

        // Store retires without freeing; dual completion to one tag keeps port 0.
        drive(1, 0, 50, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 1; i < 5; i++) drive(1, 1, 50 + i, 2'b00, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 2'b01, 0, 0, 32'h10, 0, 0);
        chk("s6_store_ret", 64'(bus.ret_valid), 64'b01);
        chk("s6_store_nofree", 64'(bus.free_push), 64'b00);
        drive(0, 0, 0, 2'b11, 1, 2, 32'h11, 32'h12, 0);
        drive(0, 0, 0, 2'b01, 3, 0, 32'h13, 0, 0);
        idle();
        drive(0, 0, 0, 2'b11, 4, 4, 32'hAA, 32'hBB, 0);
        chk("s6_dual_ret", 64'(bus.ret_valid), 64'b01);
        chk("s6_dual_data", 64'(bus.ret_data[31:0]), 64'h0AA);
        chk("s6_dual_free", 64'(bus.free_push), 64'b01);
        idle();

        // Stream 40 allocations, completing the two oldest pending entries in reverse port order.
        for (int i = 0; i < 40; i++) begin
            nd.delete();
            foreach (q[j]) if (!q[j].done) nd.push_back(q[j].tag);
            cv = (nd.size() >= 2) ? 2'b11 : (nd.size() == 1 ? 2'b10 : 2'b00);
            t1 = (nd.size() >= 1) ? nd[0] : 0;
            t0 = (nd.size() >= 2) ? nd[1] : 0;
            drive(1, 1, i, cv, t0, t1, int'($urandom), int'($urandom), 0);
        end
        for (int i = 0; i < 4; i++) begin
            nd.delete();
            foreach (q[j]) if (!q[j].done) nd.push_back(q[j].tag);
            drive(0, 0, 0, (nd.size() >= 1) ? 2'b01 : 2'b00, (nd.size() >= 1) ? nd[0] : 0, 0,
                  int'($urandom), 0, 0);
        end

        // Random traffic with an embedded mid-traffic reset.
        for (int c = 0; c < 500; c++) begin
            if (c == 200) begin
                rst = 1'b1;
                idle();
                chk_reset_state("rst_mid0");
                idle();
                chk_reset_state("rst_mid1");
                rst = 1'b0;
                idle();
                chk_reset_state("rst_after");
            end
            nd.delete();
            foreach (q[j]) if (!q[j].done) nd.push_back(q[j].tag);
            cv = 2'($urandom);
            t0 = (nd.size() > 0 && ($urandom % 8 != 0)) ? nd[$urandom % nd.size()] : int'($urandom % 16);
            t1 = (nd.size() > 0 && ($urandom % 8 != 0)) ? nd[$urandom % nd.size()] : int'($urandom % 16);
            drive(($urandom % 4) != 0, 1'($urandom), int'($urandom % 64), cv, t0, t1,
                  int'($urandom), int'($urandom), ($urandom % 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
